// File: rtl/crtc_pkg.sv
// rtl/crtc_pkg.sv - Shared register indices and cursor blink modes for the CRTC.
package crtc_pkg;

  localparam logic [3:0] R_HTOTAL   = 4'd0;
  localparam logic [3:0] R_HDISP    = 4'd1;
  localparam logic [3:0] R_HSYNCPOS = 4'd2;
  localparam logic [3:0] R_SYNCW    = 4'd3;
  localparam logic [3:0] R_VTOTAL   = 4'd4;
  localparam logic [3:0] R_VADJ     = 4'd5;
  localparam logic [3:0] R_VDISP    = 4'd6;
  localparam logic [3:0] R_VSYNCPOS = 4'd7;
  localparam logic [3:0] R_MODE     = 4'd8;
  localparam logic [3:0] R_MAXSCAN  = 4'd9;
  localparam logic [3:0] R_CURSTART = 4'd10;
  localparam logic [3:0] R_CUREND   = 4'd11;
  localparam logic [3:0] R_STARTHI  = 4'd12;
  localparam logic [3:0] R_STARTLO  = 4'd13;
  localparam logic [3:0] R_CURHI    = 4'd14;
  localparam logic [3:0] R_CURLO    = 4'd15;

  typedef enum logic [1:0] {
    CUR_STEADY = 2'b00,
    CUR_OFF    = 2'b01,
    CUR_FAST   = 2'b10,
    CUR_SLOW   = 2'b11
  } blink_mode_e;

endpackage

// File: rtl/crtc_regfile.sv
// rtl/crtc_regfile.sv - CRTC index latch, R0-R15 storage and the R12-R15 read port.
module crtc_regfile
  import crtc_pkg::*;
#(
  parameter logic [7:0] RST_HTOTAL   = 8'd56,
  parameter logic [7:0] RST_HDISP    = 8'd40,
  parameter logic [7:0] RST_HSYNCPOS = 8'd45,
  parameter logic [7:0] RST_SYNCW    = 8'h0A,
  parameter logic [7:0] RST_VTOTAL   = 8'd31,
  parameter logic [7:0] RST_VADJ     = 8'd6,
  parameter logic [7:0] RST_VDISP    = 8'd25,
  parameter logic [7:0] RST_VSYNCPOS = 8'd28,
  parameter logic [7:0] RST_MAXSCAN  = 8'd7,
  parameter logic [7:0] RST_CSTART   = 8'd6,
  parameter logic [7:0] RST_CEND     = 8'd7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             a0,
  input  logic             write,
  input  logic             read,
  input  logic [7:0]       bus_d,
  output logic [7:0]       bus_out,
  output logic [15:0][7:0] regs
);

  logic [4:0] index;

  function automatic logic [7:0] rst_val(input logic [3:0] i);
    case (i)
      R_HTOTAL:   return RST_HTOTAL;
      R_HDISP:    return RST_HDISP;
      R_HSYNCPOS: return RST_HSYNCPOS;
      R_SYNCW:    return RST_SYNCW;
      R_VTOTAL:   return RST_VTOTAL;
      R_VADJ:     return RST_VADJ;
      R_VDISP:    return RST_VDISP;
      R_VSYNCPOS: return RST_VSYNCPOS;
      R_MAXSCAN:  return RST_MAXSCAN;
      R_CURSTART: return {3'b000, RST_CSTART[4:0]};
      R_CUREND:   return RST_CEND;
      default:    return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= rst_val(4'(i));
    end else if (cs && write) begin
      if (!a0)
        index <= bus_d[4:0];
      else if (!index[4])
        regs[index[3:0]] <= bus_d;
    end
  end

  // Only the start-address and cursor registers are readable.
  always_comb begin
    bus_out = 8'h00;
    if (cs && read && a0 && (index[4:2] == 3'b011))
      bus_out = regs[index[3:0]];
  end

endmodule

// File: rtl/crtc_timing_gen.sv
// rtl/crtc_timing_gen.sv - MC6845-style CRT timing generator: counters, syncs, addressing, cursor.
module crtc_timing_gen
  import crtc_pkg::*;
#(
  parameter int          MA_W         = 14,
  parameter int          RA_W         = 5,
  parameter int          H_W          = 8,
  parameter int          V_W          = 7,
  parameter logic [7:0]  RST_HTOTAL   = 8'd56,
  parameter logic [7:0]  RST_HDISP    = 8'd40,
  parameter logic [7:0]  RST_HSYNCPOS = 8'd45,
  parameter logic [7:0]  RST_SYNCW    = 8'h0A,
  parameter logic [7:0]  RST_VTOTAL   = 8'd31,
  parameter logic [7:0]  RST_VADJ     = 8'd6,
  parameter logic [7:0]  RST_VDISP    = 8'd25,
  parameter logic [7:0]  RST_VSYNCPOS = 8'd28,
  parameter logic [7:0]  RST_MAXSCAN  = 8'd7,
  parameter logic [7:0]  RST_CSTART   = 8'd6,
  parameter logic [7:0]  RST_CEND     = 8'd7,
  parameter int          BLINK_FAST   = 16,
  parameter int          BLINK_SLOW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            divclk,
  input  logic            cs,
  input  logic            a0,
  input  logic            write,
  input  logic            read,
  input  logic [7:0]      bus_d,
  output logic [7:0]      bus_out,
  output logic            hsync,
  output logic            vsync,
  output logic            hdisp,
  output logic            vdisp,
  output logic            display_enable,
  output logic            cursor,
  output logic [MA_W-1:0] mem_addr,
  output logic [RA_W-1:0] row_addr,
  output logic            line_reset,
  output logic            frame_start
);

  localparam int BLINK_MAX = (BLINK_SLOW > BLINK_FAST) ? BLINK_SLOW : BLINK_FAST;
  localparam int BC_W      = $clog2(BLINK_MAX + 1);

  logic [15:0][7:0] regs;

  crtc_regfile #(
    .RST_HTOTAL  (RST_HTOTAL),
    .RST_HDISP   (RST_HDISP),
    .RST_HSYNCPOS(RST_HSYNCPOS),
    .RST_SYNCW   (RST_SYNCW),
    .RST_VTOTAL  (RST_VTOTAL),
    .RST_VADJ    (RST_VADJ),
    .RST_VDISP   (RST_VDISP),
    .RST_VSYNCPOS(RST_VSYNCPOS),
    .RST_MAXSCAN (RST_MAXSCAN),
    .RST_CSTART  (RST_CSTART),
    .RST_CEND    (RST_CEND)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs     (cs),
    .a0     (a0),
    .write  (write),
    .read   (read),
    .bus_d  (bus_d),
    .bus_out(bus_out),
    .regs   (regs)
  );

  logic [H_W-1:0]  hc, hc_n;
  logic [RA_W-1:0] ra, ra_n;
  logic [V_W-1:0]  vc, vc_n;
  logic            adjust, adjust_n;
  logic [MA_W-1:0] line_base, line_base_n;
  logic [4:0]      vs_left;
  logic [BC_W-1:0] blink_cnt;
  logic            blink_phase;
  logic            blink_gate;
  blink_mode_e     blink_mode;

  logic            h_end, row_end, vt_end, adj_end, vadj_zero;
  logic            h_wrap, frame_wrap, enter_adj;
  logic            hs_n, vs_rise;
  logic [31:0]     hs_start, blink_lim;
  logic [4:0]      vs_len;
  logic [RA_W-1:0] maxscan;
  logic            unused_ok;

  assign unused_ok = ^{regs[R_MODE], regs[R_MAXSCAN], regs[R_STARTHI], regs[R_CURSTART], bus_d[7:5]};

  assign maxscan   = regs[R_MAXSCAN][RA_W-1:0];
  assign vadj_zero = (regs[R_VADJ] == 8'd0);

  // >= rather than == so counters recover when a register shrinks below them.
  assign h_end   = 32'(hc) >= 32'(regs[R_HTOTAL]);
  assign row_end = ra >= maxscan;
  assign vt_end  = 32'(vc) >= 32'(regs[R_VTOTAL]);
  assign adj_end = (32'(ra) + 32'd1) >= 32'(regs[R_VADJ]);

  assign h_wrap     = divclk & h_end;
  assign frame_wrap = h_wrap & (adjust ? adj_end : (row_end & vt_end & vadj_zero));
  assign enter_adj  = h_wrap & ~adjust & row_end & vt_end & ~vadj_zero;

  always_comb begin
    hc_n        = hc;
    ra_n        = ra;
    vc_n        = vc;
    adjust_n    = adjust;
    line_base_n = line_base;
    if (divclk)
      hc_n = h_end ? '0 : hc + H_W'(1);
    if (frame_wrap) begin
      ra_n        = '0;
      vc_n        = '0;
      adjust_n    = 1'b0;
      line_base_n = MA_W'({regs[R_STARTHI][5:0], regs[R_STARTLO]});
    end else if (enter_adj) begin
      ra_n     = '0;
      adjust_n = 1'b1;
    end else if (h_wrap) begin
      if (!adjust && row_end) begin
        ra_n        = '0;
        vc_n        = vc + V_W'(1);
        line_base_n = line_base + MA_W'(regs[R_HDISP]);
      end else begin
        ra_n = ra + RA_W'(1);
      end
    end
  end

  // Syncs are registered against the next counter values so they line up with hc/vc.
  assign hs_start = 32'(regs[R_HSYNCPOS]);
  assign hs_n     = (32'(hc_n) >= hs_start) && (32'(hc_n) < hs_start + 32'(regs[R_SYNCW][3:0]));
  assign vs_rise  = h_wrap & ~adjust_n & (32'(vc_n) == 32'(regs[R_VSYNCPOS])) & (ra_n == '0);
  assign vs_len   = (regs[R_SYNCW][7:4] == 4'd0) ? 5'd16 : {1'b0, regs[R_SYNCW][7:4]};

  assign blink_mode = blink_mode_e'(regs[R_CURSTART][6:5]);
  assign blink_lim  = (blink_mode == CUR_SLOW) ? 32'(BLINK_SLOW - 1) : 32'(BLINK_FAST - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= '0;
      ra          <= '0;
      vc          <= '0;
      adjust      <= 1'b0;
      line_base   <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      vs_left     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      hc        <= hc_n;
      ra        <= ra_n;
      vc        <= vc_n;
      adjust    <= adjust_n;
      line_base <= line_base_n;
      if (divclk)
        hsync <= hs_n;
      if (vs_rise) begin
        vsync   <= 1'b1;
        vs_left <= vs_len;
      end else if (h_wrap && vsync) begin
        if (vs_left <= 5'd1) begin
          vsync   <= 1'b0;
          vs_left <= '0;
        end else begin
          vs_left <= vs_left - 5'd1;
        end
      end
      if (frame_wrap) begin
        if (32'(blink_cnt) >= blink_lim) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BC_W'(1);
        end
      end
    end
  end

  always_comb begin
    blink_gate = 1'b1;
    case (blink_mode)
      CUR_STEADY: blink_gate = 1'b1;
      CUR_OFF:    blink_gate = 1'b0;
      CUR_FAST,
      CUR_SLOW:   blink_gate = blink_phase;
      default:    blink_gate = 1'b1;
    endcase
  end

  assign hdisp          = 32'(hc) < 32'(regs[R_HDISP]);
  assign vdisp          = (32'(vc) < 32'(regs[R_VDISP])) & ~adjust;
  assign display_enable = hdisp & vdisp;
  assign mem_addr       = line_base + MA_W'(hc);
  assign row_addr       = ra;
  assign line_reset     = h_wrap;
  assign frame_start    = frame_wrap;

  assign cursor = display_enable
                & (mem_addr == MA_W'({regs[R_CURHI], regs[R_CURLO]}))
                & (32'(regs[R_CURSTART][4:0]) <= 32'(ra))
                & (32'(ra) <= 32'(regs[R_CUREND]))
                & blink_gate;

endmodule

// File: tb/tb_crtc_timing_gen.sv
// tb/tb_crtc_timing_gen.sv - Directed vector and sequence bench for crtc_timing_gen.
module tb_crtc_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n, divclk, cs, a0, write, read;
  logic [7:0]  bus_d, bus_out;
  logic        hsync, vsync, hdisp, vdisp, display_enable, cursor, line_reset, frame_start;
  logic [13:0] mem_addr;
  logic [4:0]  row_addr;

  int total = 0;
  int bad   = 0;

  crtc_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .divclk(divclk), .cs(cs), .a0(a0), .write(write), .read(read),
    .bus_d(bus_d), .bus_out(bus_out), .hsync(hsync), .vsync(vsync), .hdisp(hdisp), .vdisp(vdisp),
    .display_enable(display_enable), .cursor(cursor), .mem_addr(mem_addr), .row_addr(row_addr),
    .line_reset(line_reset), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       cs, a0, wr, rd;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [7:0] idx, input logic [7:0] val);
    @(negedge clk); cs = 1; a0 = 0; write = 1; bus_d = idx;
    @(negedge clk); a0 = 1; bus_d = val;
    @(negedge clk); cs = 0; a0 = 0; write = 0;
  endtask

  task automatic wait_fs(input int lim);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < lim);
    chk("frame_start_seen", frame_start, 1);
  endtask

  task automatic wait_lr(input int lim);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!line_reset && n < lim);
    chk("line_reset_seen", line_reset, 1);
  endtask

  int   hcm, ln, n, c, badpos, t, run, vs_cnt, vs_first, fs_cnt, fs_pos, hs_cnt;
  logic vis[48];

  initial begin
    rst_n = 0; divclk = 0; cs = 0; a0 = 0; write = 0; read = 0; bus_d = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    chk("rst_hdisp", hdisp, 1);
    chk("rst_vdisp", vdisp, 1);
    chk("rst_de", display_enable, 1);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_row_addr", row_addr, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_line_reset", line_reset, 0);
    chk("rst_frame_start", frame_start, 0);

    //             cs  a0  wr  rd  data   expected bus_out
    vecs[0]  = '{1, 0, 1, 0, 8'd14, 8'h00};
    vecs[1]  = '{1, 1, 0, 1, 8'h00, 8'h00};
    vecs[2]  = '{1, 0, 1, 0, 8'd12, 8'h00};
    vecs[3]  = '{1, 1, 1, 0, 8'hA5, 8'h00};
    vecs[4]  = '{1, 1, 0, 1, 8'h00, 8'hA5};
    vecs[5]  = '{0, 1, 0, 1, 8'h00, 8'h00};
    vecs[6]  = '{1, 0, 0, 1, 8'h00, 8'h00};
    vecs[7]  = '{1, 0, 1, 0, 8'd28, 8'h00};
    vecs[8]  = '{1, 1, 1, 0, 8'h33, 8'h00};
    vecs[9]  = '{1, 1, 0, 1, 8'h00, 8'h00};
    vecs[10] = '{1, 0, 1, 0, 8'd12, 8'h00};
    vecs[11] = '{1, 1, 0, 1, 8'h00, 8'hA5};
    vecs[12] = '{1, 0, 1, 0, 8'd5,  8'h00};
    vecs[13] = '{1, 1, 0, 1, 8'h00, 8'h00};
    vecs[14] = '{1, 0, 1, 0, 8'd15, 8'h00};
    vecs[15] = '{1, 1, 1, 0, 8'h3C, 8'h00};
    vecs[16] = '{1, 1, 0, 1, 8'h00, 8'h3C};
    vecs[17] = '{1, 1, 1, 1, 8'h11, 8'h3C};
    vecs[18] = '{1, 1, 0, 1, 8'h00, 8'h11};

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      cs = vecs[i].cs; a0 = vecs[i].a0; write = vecs[i].wr; read = vecs[i].rd; bus_d = vecs[i].d;
      #1;
      chk($sformatf("vec%0d_bus_out", i), bus_out, vecs[i].exp);
    end
    @(negedge clk); cs = 0; a0 = 0; write = 0; read = 0;

    write_reg(0, 9);  write_reg(1, 6);  write_reg(2, 7);  write_reg(3, 8'h22);
    write_reg(4, 3);  write_reg(5, 2);  write_reg(6, 2);  write_reg(7, 3);
    write_reg(9, 1);  write_reg(12, 0); write_reg(13, 8'h50);
    divclk = 1;

    // One full 10-line frame against a cycle model of the programmed timing.
    wait_fs(300);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      hcm = k % 10; ln = k / 10;
      chk($sformatf("k%0d_hsync", k), hsync, (hcm >= 7 && hcm < 9));
      chk($sformatf("k%0d_vsync", k), vsync, (ln == 6 || ln == 7));
      chk($sformatf("k%0d_hdisp", k), hdisp, (hcm < 6));
      chk($sformatf("k%0d_vdisp", k), vdisp, (ln < 4));
      chk($sformatf("k%0d_de", k), display_enable, (hcm < 6 && ln < 4));
      chk($sformatf("k%0d_line_reset", k), line_reset, (hcm == 9));
      chk($sformatf("k%0d_frame_start", k), frame_start, (k == 99));
      chk($sformatf("k%0d_cursor", k), cursor, 0);
      if (ln < 8) begin
        chk($sformatf("k%0d_mem_addr", k), mem_addr, 32'h50 + (ln / 2) * 6 + hcm);
        chk($sformatf("k%0d_row_addr", k), row_addr, ln % 2);
      end else begin
        chk($sformatf("k%0d_row_addr_adj", k), row_addr, ln - 8);
      end
    end

    // Cursor at 0x52, fast blink: runs of 16 visible then 16 hidden frames.
    write_reg(14, 8'h00); write_reg(15, 8'h52); write_reg(10, 8'h40); write_reg(11, 8'h01);
    wait_fs(300);
    for (int f = 0; f < 48; f++) begin
      c = 0; badpos = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (cursor) begin
          c++;
          if (k != 2 && k != 12) badpos++;
        end
      end
      vis[f] = (c != 0);
      chk($sformatf("f%0d_cursor_count_0_or_2", f), (c == 0 || c == 2), 1);
      chk($sformatf("f%0d_cursor_pos", f), badpos, 0);
    end
    t = 0;
    for (int f = 1; f <= 16; f++)
      if (t == 0 && vis[f] != vis[f-1]) t = f;
    chk("blink_edge_found", (t != 0), 1);
    if (t != 0) begin
      run = 0;
      for (int f = t; f < 48 && vis[f] == vis[t]; f++) run++;
      chk("blink_run_len", run, 16);
    end

    write_reg(10, 8'h20);
    wait_fs(300);
    c = 0;
    for (int k = 0; k < 100; k++) begin @(negedge clk); if (cursor) c++; end
    chk("cursor_mode_off", c, 0);
    write_reg(10, 8'h00);
    wait_fs(300);
    c = 0;
    for (int k = 0; k < 100; k++) begin @(negedge clk); if (cursor) c++; end
    chk("cursor_mode_steady", c, 2);

    // vsync width field 0 means 16 lines; lengthen the frame to 34 lines to see it.
    write_reg(4, 15); write_reg(3, 8'h02);
    wait_fs(500);
    wait_fs(500);
    vs_cnt = 0; vs_first = -1; fs_cnt = 0; fs_pos = -1;
    for (int k = 0; k < 340; k++) begin
      @(negedge clk);
      if (vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = k;
      end
      if (frame_start) begin fs_cnt++; fs_pos = k; end
    end
    chk("vsync16_cycles", vs_cnt, 160);
    chk("vsync16_first", vs_first, 60);
    chk("frame34_fs_count", fs_cnt, 1);
    chk("frame34_fs_pos", fs_pos, 339);

    // Shrink R0 to 4 while hc sits at 8.
    @(negedge clk); cs = 1; a0 = 0; write = 1; bus_d = 0;
    @(negedge clk); cs = 0; write = 0;
    wait_lr(50);
    repeat (9) @(negedge clk);
    cs = 1; a0 = 1; write = 1; bus_d = 4;
    @(negedge clk); cs = 0; a0 = 0; write = 0;
    chk("r0_shrink_wrap_now", line_reset, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!line_reset && n < 300);
    chk("r0_shrink_new_period", n, 5);

    // Reset in the middle of vsync.
    n = 0;
    do begin @(negedge clk); n++; end while (!vsync && n < 400);
    chk("vsync_seen_before_reset", vsync, 1);
    rst_n = 0;
    #1;
    chk("midrst_vsync", vsync, 0);
    chk("midrst_hsync", hsync, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_row_addr", row_addr, 0);
    chk("midrst_hdisp", hdisp, 1);
    chk("midrst_line_reset", line_reset, 0);
    @(negedge clk);
    chk("midrst_vsync_held", vsync, 0);
    rst_n = 1;
    wait_lr(100);
    n = 0; hs_cnt = 0;
    do begin
      @(negedge clk); n++;
      if (hsync) hs_cnt++;
    end while (!line_reset && n < 200);
    chk("post_rst_line_period", n, 57);
    chk("post_rst_hsync_width", hs_cnt, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
